picomem_arb_2_1: RTL
====================

// Module: picomem_arb_2_1
// PURPOSE
//  Round-robin arbiter that shares one PicoMem slave port (e.g. the top-level 1:4 mux input)
//  between two PicoMem masters: CPU on m0, DMA/debug on m1. One transaction in flight at a time.
//  A watchdog counter completes hung transactions so neither master stalls forever.
// PARAMETERS
//  TIMEOUT_CYCLES  1024          slave cycles without ready before forced completion; 0 = disabled
//  TIMEOUT_RDATA   32'hDEAD_BEEF rdata returned to the master on a timed-out access
//  M0_FIRST        1             priority pointer after reset: 1 = m0 wins the first tie
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  m0_valid     in   1   master 0 request; held with addr/wdata/wstrb until m0_ready
//  m0_ready     out  1   master 0 completion strobe, one cycle
//  m0_addr      in   32  master 0 address
//  m0_wdata     in   32  master 0 write data
//  m0_wstrb     in   4   master 0 byte strobes; 0 = read
//  m0_rdata     out  32  master 0 read data, valid when m0_ready
//  m1_*         (same six signals and widths as m0_*, for master 1)
//  s_valid      out  1   request to shared slave
//  s_ready      in   1   slave completion strobe
//  s_addr       out  32  granted master's address
//  s_wdata      out  32  granted master's write data
//  s_wstrb      out  4   granted master's byte strobes
//  s_rdata      in   32  slave read data
//  timeout_evt  out  1   one-cycle pulse when the watchdog fires
//  owner        out  1   current/last grant holder (0 = m0, 1 = m1)
// BEHAVIOUR
//  Reset (async, any cycle, including mid-transaction): state=IDLE; s_valid, m0_ready, m1_ready
//   and timeout_evt = 0; s_addr/s_wdata/s_rdata paths = 0; s_wstrb = 0; owner = 0;
//   pointer = M0_FIRST ? m0 : m1; watchdog = 0. Any in-flight access is dropped without ready.
//  States: IDLE, BUSY. The registered 'owner' selects the master.
//  IDLE: if exactly one mN_valid, grant N. If both, grant the pointer's master. Register owner,
//   go BUSY. No request: stay IDLE. s_valid = 0 in IDLE (1-cycle arbitration latency).
//  BUSY: s_valid = 1; s_addr/s_wdata/s_wstrb = mux(owner) (combinational from the master).
//   mOWNER_ready = s_ready and mOWNER_rdata = s_rdata (combinational pass-through).
//   The non-owner's ready = 0 and rdata = 0.
//  Completion (s_ready=1 in BUSY): -> IDLE; pointer := other master (fair alternation);
//   watchdog := 0. Back-to-back requests from the same master with the other idle are granted
//   again after 1 IDLE cycle, so steady-state throughput = 1 access per (slave latency + 1) cycles.
//  Owner drops valid in BUSY without ready (protocol violation): -> IDLE next cycle; s_valid
//   drops; no ready issued; pointer unchanged.
//  Watchdog: counts BUSY cycles with s_ready=0. When count == TIMEOUT_CYCLES-1 and s_ready=0:
//   - mOWNER_ready = 1 and mOWNER_rdata = TIMEOUT_RDATA for that cycle
//   - timeout_evt = 1 for that cycle
//   - -> IDLE, pointer flips
//   s_ready on that same cycle takes precedence: normal completion, no timeout_evt.
//   Counter width = clog2(TIMEOUT_CYCLES)+1; saturating; never wraps.
//  Late slave ready after a timeout, seen in IDLE, is ignored (not forwarded).
//  Writes are never split or retried. s_wstrb is forwarded unchanged.
//  m0/m1 signals are never forwarded to the slave outside BUSY.
// TESTING
//  1 single m0 read, slave ready 2 cycles after s_valid, rdata=32'h1234_5678:
//    -> m0_ready 1 cycle, m0_rdata=32'h1234_5678, m1_ready=0, owner=0
//  2 m0,m1 valid same cycle after reset (M0_FIRST=1), 4 back-to-back each:
//    -> grants m0,m1,m0,m1,... strictly alternating
//  3 m1 write addr=32'h4000_0010 wdata=32'hCAFE_F00D wstrb=4'b0011:
//    -> s_* match exactly while BUSY; m0_valid=0 throughout
//  4 TIMEOUT_CYCLES=8, slave never ready on m0 read:
//    -> m0_ready and timeout_evt on 8th BUSY cycle, m0_rdata=32'hDEAD_BEEF, then grant to waiting m1
//  5 s_ready on exactly the 8th BUSY cycle (TIMEOUT_CYCLES=8):
//    -> normal completion with slave rdata, timeout_evt=0
//  6 reset asserted mid-BUSY on an m1 access:
//    -> s_valid and all ready = 0 immediately (async); after release, first tie goes to m0

Source files
------------

// File: rtl/picomem_arb_2_1.sv
// Two-master round-robin arbiter in front of a single PicoMem slave port.
// One access in flight; a watchdog force-completes accesses the slave never acks.
module picomem_arb_2_1 #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF,
  parameter bit          M0_FIRST       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_evt,
  output logic        owner
);

  localparam int          CW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] WD_LAST = WD_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          ptr_q, ptr_d;       // 0 = m0 wins a tie, 1 = m1 wins a tie
  logic [CW-1:0] wd_q, wd_d;

  logic        busy, own_valid, done, fire, ack;
  logic [31:0] rd;

  // Transaction qualifiers; a dropped valid suppresses both completion and timeout
  always_comb begin
    busy      = (state_q == BUSY);
    own_valid = owner_q ? m1_valid : m0_valid;
    done      = busy & own_valid & s_ready;
    fire      = busy & own_valid & ~s_ready & WD_EN & (wd_q == WD_LAST);
    ack       = done | fire;
    rd        = fire ? TIMEOUT_RDATA : s_rdata;
  end

  // State, grant owner, tie pointer and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= ~M0_FIRST;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ack / timeout / abandon in BUSY
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (m0_valid | m1_valid) begin
          owner_d = m1_valid & (~m0_valid | ptr_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_valid) begin
          // master abandoned the request: no ready, pointer kept
          state_d = IDLE;
          wd_d    = '0;
        end else if (ack) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
          wd_d    = '0;
        end else if (wd_q != '1) begin
          wd_d = wd_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave-side request mux and master-side response demux, gated by BUSY
  always_comb begin
    s_valid     = busy;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = ack & ~owner_q;
    m1_ready    = ack & owner_q;
    m0_rdata    = '0;
    m1_rdata    = '0;
    timeout_evt = fire;
    owner       = owner_q;
    if (busy) begin
      s_addr  = owner_q ? m1_addr  : m0_addr;
      s_wdata = owner_q ? m1_wdata : m0_wdata;
      s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
      if (owner_q) m1_rdata = rd;
      else         m0_rdata = rd;
    end
  end

endmodule
